hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Sequencing controller for the decode stage (register-file read, sign-extend and write-back select) of the 5-stage RISC-V pipeline.
- Tracks the destination register of every in-flight instruction in EX, MEM and WB in an internal scoreboard.
- From that scoreboard it produces the load-use stall, the EX bubble and the branch flush.
- It also produces the per-operand forwarding selects that steer rD1/rD2 replacement muxes.

Parameters:
- XLEN, 32, width of the stall performance counter.
- NREG_BITS, 5, register index width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- hold  in  1  global freeze (memory wait); no state advances while high.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  5  ID source 1 index (din[19:15]).
- id_rs2  in  5  ID source 2 index (din[24:20]).
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2_used  in  1  instruction reads rs2.
- id_rd  in  5  ID destination (din[11:7]).
- id_rf_we  in  1  ID instruction writes RF.
- id_rf_wsel  in  2  ID write-back source (RF_WSEL_* encoding).
- ex_branch_taken  in  1  EX resolved a taken branch/jump.
- stall_if_id  out  1  hold PC and IF/ID register.
- bubble_ex  out  1  load a NOP into ID/EX.
- flush_if_id  out  1  invalidate IF/ID register.
- fwd_a  out  2  rD1 source: 0 RF, 1 EX, 2 MEM, 3 WB.
- fwd_b  out  2  rD2 source, same encoding.
- stall_cnt  out  XLEN  count of load-use stall cycles.

Behaviour:
- Scoreboard: three slots EX, MEM, WB. Each slot holds {valid, rd, we, is_load}.
- is_load = (id_rf_wsel == RF_WSEL_RDO) captured at entry.
- Reset (async, rst_n low): all slot valid = 0, stall_cnt = 0. All outputs then read 0.
- Every rising edge with hold = 0: WB <= MEM, MEM <= EX, EX <= new entry.
  - New entry = {id_valid, id_rd, id_rf_we, is_load} normally.
  - New entry = invalid when bubble_ex = 1.
- hold = 1: slots and stall_cnt keep their values. Outputs remain combinational on the current inputs.
- A slot "matches" operand rsN when all of: slot valid, we = 1, rd == rsN, rsN != 0, rsN_used = 1, id_valid = 1.
- load_use = (EX matches rs1 or rs2) and EX.is_load.
- Output equations (combinational):
  - stall_if_id = load_use & ~ex_branch_taken.
  - bubble_ex = load_use | ex_branch_taken.
  - flush_if_id = ex_branch_taken.
- Branch precedence: a taken branch overrides a load-use stall. The ID instruction is killed, so no stall is needed.
- Forward select, priority EX > MEM > WB > RF:
  - EX match and not load: 1.
  - Else MEM match: 2. Covers a load's dram_rdo as well as ALU/PC4/EXT results.
  - Else WB match: 3.
  - Else 0.
  - During load_use the select for the matched operand is 0 (don't-care; drives 0 for determinism).
- x0 is never forwarded and never causes a stall.
- stall_cnt increments by 1 on each non-held edge where stall_if_id = 1. It wraps modulo 2^XLEN.
- A back-to-back load followed by a dependent instruction produces exactly one stall cycle, then fwd = 2.
- Reset asserted mid-stall: the stall drops immediately, because outputs derive from slots that are cleared asynchronously.

Decomposition:
- Shared package/header additions:
  - FWD_RF/FWD_EX/FWD_MEM/FWD_WB 2-bit constants.
  - A scoreboard slot struct or field-width defines.
  - Reuse the existing RF_WSEL_* defines.
- One natural sub-module: hazard_fwd_sel (combinational per-operand priority select). It is instantiated twice, for rs1 and rs2.

Test Plan:
- add x5 then add x6,x5,x1 back-to-back -> fwd_a = 1, no stall, stall_cnt stays 0.
- lw x5 then add x6,x1,x5 -> cycle 1: stall_if_id = 1, bubble_ex = 1. Cycle 2: fwd_b = 2. stall_cnt = 1.
- lw x5 followed by a taken branch in EX in the same cycle -> flush_if_id = 1, bubble_ex = 1, stall_if_id = 0, stall_cnt unchanged.
- Writes to x0 then a read of x0, and x7 written 3 instructions earlier -> x0: fwd = 0, no stall. x7 at distance 3: fwd = 3.
- Dependent instruction arrives while hold = 1 for 4 cycles -> slots frozen, stall_if_id held stable, stall_cnt unchanged until hold drops.
- rst_n pulsed low during a load-use stall -> all outputs 0 immediately and stall_cnt = 0. After release, the first dependent pair behaves as in the second scenario.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared constants, scoreboard slot type and operand-match helper
package hazard_ctrl_pkg;
  localparam int REG_BITS = 5;
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;
  localparam logic [1:0] RF_WSEL_ALU = 2'd0;
  localparam logic [1:0] RF_WSEL_RDO = 2'd1;
  localparam logic [1:0] RF_WSEL_PC4 = 2'd2;
  localparam logic [1:0] RF_WSEL_EXT = 2'd3;
  typedef struct packed {
    logic                valid;
    logic [REG_BITS-1:0] rd;
    logic                we;
    logic                is_load;
  } sb_slot_t;
  // x0 is hard-wired zero, so it never matches a producer
  function automatic logic slot_hit(sb_slot_t s, logic [REG_BITS-1:0] rs, logic used);
    return s.valid & s.we & (s.rd == rs) & (rs != '0) & used;
  endfunction
endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// hazard_fwd_sel: per-operand forwarding priority EX > MEM > WB > RF
module hazard_fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  sb_slot_t            ex_i,
  input  sb_slot_t            mem_i,
  input  sb_slot_t            wb_i,
  input  logic [REG_BITS-1:0] rs_i,
  input  logic                used_i,
  output logic [1:0]          sel_o,
  output logic                ld_hit_o
);
  logic ex_hit, mem_hit, wb_hit;
  always_comb begin
    ex_hit   = slot_hit(ex_i, rs_i, used_i);
    mem_hit  = slot_hit(mem_i, rs_i, used_i);
    wb_hit   = slot_hit(wb_i, rs_i, used_i);
    ld_hit_o = ex_hit & ex_i.is_load;
    sel_o    = ex_hit  ? (ex_i.is_load ? FWD_RF : FWD_EX) :
               mem_hit ? FWD_MEM :
               wb_hit  ? FWD_WB  : FWD_RF;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: EX/MEM/WB destination scoreboard driving load-use stall,
// branch flush and operand forwarding selects for the decode stage
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREG_BITS = REG_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hold,
  input  logic                 id_valid,
  input  logic [NREG_BITS-1:0] id_rs1,
  input  logic [NREG_BITS-1:0] id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [NREG_BITS-1:0] id_rd,
  input  logic                 id_rf_we,
  input  logic [1:0]           id_rf_wsel,
  input  logic                 ex_branch_taken,
  output logic                 stall_if_id,
  output logic                 bubble_ex,
  output logic                 flush_if_id,
  output logic [1:0]           fwd_a,
  output logic [1:0]           fwd_b,
  output logic [XLEN-1:0]      stall_cnt
);
  sb_slot_t ex_q, mem_q, wb_q, ex_d;
  logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;
  logic ld_a, ld_b, load_use;

  hazard_fwd_sel u_fwd_a (
    .ex_i(ex_q), .mem_i(mem_q), .wb_i(wb_q), .rs_i(id_rs1),
    .used_i(id_rs1_used & id_valid), .sel_o(fwd_a), .ld_hit_o(ld_a)
  );
  hazard_fwd_sel u_fwd_b (
    .ex_i(ex_q), .mem_i(mem_q), .wb_i(wb_q), .rs_i(id_rs2),
    .used_i(id_rs2_used & id_valid), .sel_o(fwd_b), .ld_hit_o(ld_b)
  );

  // a taken branch kills the ID instruction, so it never needs to stall
  always_comb begin
    load_use    = ld_a | ld_b;
    stall_if_id = load_use & ~ex_branch_taken;
    bubble_ex   = load_use | ex_branch_taken;
    flush_if_id = ex_branch_taken;
    ex_d        = bubble_ex ? '0 : {id_valid, id_rd, id_rf_we, id_rf_wsel == RF_WSEL_RDO};
    stall_cnt_d = stall_cnt_q + {{(XLEN-1){1'b0}}, stall_if_id};
    stall_cnt   = stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else if (!hold) begin
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      wb_q        <= mem_q;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed + random stimulus against an instruction-history
// reference model; a negedge monitor pops expected outputs from a queue
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic clk = 0, rst_n = 0, hold = 0, id_valid = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic id_rs1_used = 0, id_rs2_used = 0, id_rf_we = 0, ex_branch_taken = 0;
  logic [1:0] id_rf_wsel = 0;
  logic stall_if_id, bubble_ex, flush_if_id;
  logic [1:0] fwd_a, fwd_b;
  logic [31:0] stall_cnt;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rf_we(id_rf_we), .id_rf_wsel(id_rf_wsel),
    .ex_branch_taken(ex_branch_taken), .stall_if_id(stall_if_id), .bubble_ex(bubble_ex),
    .flush_if_id(flush_if_id), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {bit v; int rd; bit we; bit ld;} instr_t;
  typedef struct {bit stall; bit bubble; bit flush; int fa; int fb; longint cnt;} exp_t;

  instr_t hist [3];
  longint model_cnt = 0;
  exp_t exp_q[$];
  exp_t last;
  int errors = 0, checks = 0;

  function automatic int nearest_writer(int rs, bit used);
    if (!used || !id_valid || rs == 0) return -1;
    for (int d = 0; d < 3; d++)
      if (hist[d].v && hist[d].we && hist[d].rd == rs) return d;
    return -1;
  endfunction

  function automatic int fwd_of(int d);
    if (d < 0) return 0;
    if (d == 0) return hist[0].ld ? 0 : 1;
    return d + 1;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int da, db;
    bit lu;
    da = nearest_writer(int'(id_rs1), id_rs1_used);
    db = nearest_writer(int'(id_rs2), id_rs2_used);
    lu = (da == 0 && hist[0].ld) || (db == 0 && hist[0].ld);
    e.stall  = lu && !ex_branch_taken;
    e.bubble = lu || ex_branch_taken;
    e.flush  = ex_branch_taken;
    e.fa     = fwd_of(da);
    e.fb     = fwd_of(db);
    e.cnt    = model_cnt;
    return e;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 0};
    model_cnt = 0;
  endtask

  task automatic step(bit v, int rs1, int rs2, bit u1, bit u2, int rd, bit we,
                      logic [1:0] wsel, bit br, bit hd);
    id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rs1_used = u1; id_rs2_used = u2;
    id_rd = 5'(rd); id_rf_we = we; id_rf_wsel = wsel; ex_branch_taken = br; hold = hd;
    #0;
    last = model_out();
    exp_q.push_back(last);
    @(posedge clk);
    if (!hd) begin
      model_cnt = (model_cnt + (last.stall ? 1 : 0)) & 64'hFFFF_FFFF;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = last.bubble ? '{0, 0, 0, 0} : '{v, rd, we, wsel == RF_WSEL_RDO};
    end
    #1;
  endtask

  task automatic pulse_reset();
    ex_branch_taken = 0;
    rst_n = 0;
    clear_model();
    #0;
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stall_if_id", longint'(stall_if_id), longint'(e.stall));
      chk("bubble_ex", longint'(bubble_ex), longint'(e.bubble));
      chk("flush_if_id", longint'(flush_if_id), longint'(e.flush));
      chk("fwd_a", longint'(fwd_a), longint'(e.fa));
      chk("fwd_b", longint'(fwd_b), longint'(e.fb));
      chk("stall_cnt", longint'(stall_cnt), e.cnt);
    end
  end

  initial begin
    clear_model();
    @(posedge clk); #1;
    exp_q.push_back(model_out());
    @(posedge clk); #1;
    rst_n = 1;
    // ALU producer then dependent consumer: EX forward, no stall
    step(1, 0, 0, 0, 0, 5, 1, RF_WSEL_ALU, 0, 0);
    step(1, 5, 1, 1, 1, 6, 1, RF_WSEL_ALU, 0, 0);
    // load then dependent: one stall, then MEM forward
    step(1, 0, 0, 0, 0, 5, 1, RF_WSEL_RDO, 0, 0);
    step(1, 1, 5, 1, 1, 6, 1, RF_WSEL_ALU, 0, 0);
    step(1, 1, 5, 1, 1, 6, 1, RF_WSEL_ALU, 0, 0);
    // load-use with taken branch in EX: flush wins, no stall
    step(1, 0, 0, 0, 0, 5, 1, RF_WSEL_RDO, 0, 0);
    step(1, 5, 2, 1, 1, 6, 1, RF_WSEL_ALU, 1, 0);
    // x7 at distance 3, x0 writers in between
    step(1, 0, 0, 0, 0, 7, 1, RF_WSEL_ALU, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, RF_WSEL_RDO, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, RF_WSEL_ALU, 0, 0);
    step(1, 7, 0, 1, 1, 8, 1, RF_WSEL_ALU, 0, 0);
    // dependent on a load while frozen for 4 cycles
    step(1, 0, 0, 0, 0, 9, 1, RF_WSEL_RDO, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 9, 9, 1, 1, 10, 1, RF_WSEL_ALU, 0, 1);
    step(1, 9, 9, 1, 1, 10, 1, RF_WSEL_ALU, 0, 0);
    step(1, 9, 9, 1, 1, 10, 1, RF_WSEL_ALU, 0, 0);
    // reset during a stall, then a fresh dependent pair
    step(1, 0, 0, 0, 0, 5, 1, RF_WSEL_RDO, 0, 0);
    id_valid = 1; id_rs2 = 5; id_rs2_used = 1; #1;
    pulse_reset();
    step(1, 0, 0, 0, 0, 5, 1, RF_WSEL_RDO, 0, 0);
    step(1, 1, 5, 1, 1, 6, 1, RF_WSEL_ALU, 0, 0);
    step(1, 1, 5, 1, 1, 6, 1, RF_WSEL_ALU, 0, 0);
    // random traffic over a small register window to provoke hazards
    for (int i = 0; i < 400; i++)
      step($urandom_range(7) != 0, $urandom_range(7), $urandom_range(7),
           $urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(7),
           $urandom_range(3) != 0, 2'($urandom_range(3)),
           $urandom_range(7) == 0, $urandom_range(5) == 0);
    @(negedge clk); #1;
    chk("queue_drained", longint'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
